mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Executes the single memory access of a multi-cycle instruction during the MEM stage. It sits directly downstream of the stage controller and the EX/MEM latch. It receives a one-cycle start strobe plus the latched access descriptor, and runs a request/ready handshake with the data RAM port. It returns aligned, extended load data and a one-cycle done pulse, which the controller waits for before advancing to MEM/WB.

## Interface
- ADDR_W, 17: word-address width of the data RAM port.
- TIMEOUT, 255: maximum REQ cycles without mem_ready before an error abort; 0 disables the timeout.
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle strobe: begin an access (sampled only in IDLE).
- op_load  in  1  access is a load.
- op_store  in  1  access is a store.
- size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- sign_ext  in  1  sign-extend byte/half loads when 1, zero-extend when 0.
- addr  in  32  byte address.
- wdata  in  32  store data, right-aligned.
- mem_req  out  1  request valid toward RAM.
- mem_we  out  1  request is a write.
- mem_addr  out  ADDR_W  word address, equal to addr[ADDR_W+1:2].
- mem_be  out  4  byte enables, little-endian.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  read word, valid in the cycle mem_ready=1.
- mem_ready  in  1  RAM accepts and completes the request this cycle.
- rdata  out  32  extended load result.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high in every state except IDLE.
- err  out  1  status of the last access (misaligned, illegal, or timeout); valid with done and held until the next start.

## Operation
- States: IDLE, REQ, DONE.
- IDLE:
  - start=1 registers op_load, op_store, size, sign_ext, addr and wdata.
  - A legal access goes to REQ.
  - A fault goes to DONE with err=1 and never asserts mem_req.
  - start=0 stays in IDLE.
- Faults:
  - size=11.
  - op_load and op_store both 1.
  - Half access with addr[0]=1.
  - Word access with addr[1:0]≠0.
- No-op: op_load=op_store=0 with no fault goes to DONE with err=0 and no request.
- REQ:
  - mem_req=1; mem_we equals the registered op_store.
  - mem_addr, mem_be and mem_wdata are driven from registers and are stable for the whole REQ state.
  - mem_ready=1 goes to DONE. For a load, the extended result is captured into rdata in the same edge.
  - Timeout counter: 8-bit or wider, cleared on REQ entry, incremented each REQ cycle without ready. At count==TIMEOUT-1 with no ready, go to DONE with err=1, and rdata is not written.
- DONE: done=1 for exactly one cycle, then IDLE.
- start while busy: ignored; no queueing.
- Byte lanes (lane = addr[1:0]):
  - Byte: be=4'b0001<<lane; wdata is {4{wdata[7:0]}}.
  - Half: be=4'b0011<<lane; wdata is {2{wdata[15:0]}}.
  - Word: be=4'b1111; wdata is passed through.
- Load extraction:
  - Byte: mem_rdata[8*lane+:8].
  - Half: mem_rdata[8*lane+:16].
  - Both are extended to 32 bits according to sign_ext.
- rdata changes only on a successful load. Stores, no-ops and faults leave it unchanged.

## Timing
- Reset: state IDLE. mem_req, mem_we, mem_be, mem_addr, mem_wdata, rdata, done, busy, err and the counter are all 0.
- Reset mid-access: mem_req drops at the next edge and no done is issued.
- Latency, with start sampled at edge 0:
  - REQ is entered at edge 1.
  - Ready on the first REQ cycle gives done=1 in the cycle after edge 2.
  - Total latency is 2+W cycles, where W is the number of wait cycles.
- Faults and no-ops: done is high in the cycle after edge 1, with no mem_req cycle.
- mem_ready outside REQ is ignored.
- Handshake: mem_req is never deasserted in REQ before mem_ready or timeout.
- Timeout: the abort edge is TIMEOUT cycles after REQ entry.

## Test plan
- Word load at addr 0x100, mem_ready on the first REQ cycle, mem_rdata=0xDEADBEEF → mem_addr=0x40, be=1111, rdata=0xDEADBEEF, done two cycles after start, err=0.
- Signed byte load at addr 0x103, mem_rdata=0x80AABBCC → be=1000, rdata=0xFFFFFF80. The same access with sign_ext=0 → rdata=0x00000080.
- Half store of wdata=0x1234ABCD at addr 0x202 with 3 wait cycles → mem_req held 4 cycles, we=1, be=1100, mem_wdata=0xABCDABCD, rdata unchanged, done on cycle 5.
- Word load at addr 0x2 and half load at addr 0x5 → no mem_req, done on the following cycle, err=1, rdata unchanged.
- TIMEOUT=4 with mem_ready held 0 → mem_req high exactly 4 cycles, then done with err=1.
- start pulsed during REQ is ignored. Reset asserted mid-REQ → mem_req=0 and busy=0 after the next edge, with no done.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: performs the single data-RAM access of a multi-cycle
// instruction. It decodes and checks the access descriptor when start is
// seen in IDLE, runs a req/ready handshake (with an optional timeout), then
// returns lane-aligned, extended load data with a one-cycle done pulse.
module mem_access_unit #(
    parameter int ADDR_W  = 17,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              op_load,
    input  logic              op_store,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              busy,
    output logic              err
);

    // The counter is at least 8 bits and grows only for larger timeouts.
    localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q;
    logic              op_load_q;
    logic [1:0]        size_q;
    logic              sign_ext_q;
    logic [1:0]        lane_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [3:0]        mem_be_q;
    logic [31:0]       mem_wdata_q;
    logic [31:0]       rdata_q;
    logic              done_q;
    logic              busy_q;
    logic              err_q;

    // Next values derived from the incoming descriptor and from the read word.
    logic              fault_d;
    logic [3:0]        be_d;
    logic [31:0]       wdata_d;
    logic [31:0]       lane_word;
    logic [31:0]       load_d;

    // Decode the descriptor offered with start: lane enables, store data
    // replication and the alignment/legality check.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        fault_d = 1'b0;
        be_d    = 4'b0000;
        wdata_d = wdata;
        case (size)
            2'b00: begin
                be_d    = 4'b0001 << addr[1:0];
                wdata_d = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << addr[1:0];
                wdata_d = {2{wdata[15:0]}};
                fault_d = addr[0];
            end
            2'b10: begin
                be_d    = 4'b1111;
                wdata_d = wdata;
                fault_d = |addr[1:0];
            end
            default: fault_d = 1'b1;
        endcase
        if (op_load && op_store) begin
            fault_d = 1'b1;
        end
    end

    // Pull the addressed byte/half down to bit 0 and extend it.
    always_comb begin
        lane_word = mem_rdata >> {lane_q, 3'b000};
        load_d    = mem_rdata;
        case (size_q)
            2'b00:   load_d = sign_ext_q ? {{24{lane_word[7]}}, lane_word[7:0]}
                                         : {24'h000000, lane_word[7:0]};
            2'b01:   load_d = sign_ext_q ? {{16{lane_word[15]}}, lane_word[15:0]}
                                         : {16'h0000, lane_word[15:0]};
            default: load_d = mem_rdata;
        endcase
    end

    // Access sequencer: IDLE -> (REQ) -> DONE -> IDLE, all outputs registered.
    always_ff @(posedge clk) begin
        // NOTE: the reset is synchronous, so it lives inside the clocked
        // branch and is not in the sensitivity list.
        if (reset) begin
            state_q     <= S_IDLE;
            op_load_q   <= 1'b0;
            size_q      <= 2'b00;
            sign_ext_q  <= 1'b0;
            lane_q      <= 2'b00;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'h0;
            rdata_q     <= 32'h0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register update from
            // the values present before the edge, independent of order.
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_load_q   <= op_load;
                        size_q      <= size;
                        sign_ext_q  <= sign_ext;
                        lane_q      <= addr[1:0];
                        mem_addr_q  <= addr[ADDR_W+1:2];
                        mem_be_q    <= be_d;
                        mem_wdata_q <= wdata_d;
                        err_q       <= fault_d;
                        cnt_q       <= '0;
                        busy_q      <= 1'b1;
                        if (fault_d || (!op_load && !op_store)) begin
                            // Faults and no-ops complete without touching RAM.
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= S_REQ;
                            mem_req_q <= 1'b1;
                            mem_we_q  <= op_store;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ready) begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (op_load_q) begin
                            rdata_q <= load_d;
                        end
                    end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        err_q     <= 1'b1;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= S_IDLE;
                    done_q    <= 1'b0;
                    busy_q    <= 1'b0;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign rdata     = rdata_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: hand-computed vectors covering loads,
// stores, lane handling, faults, no-op, timeout, ignored start and reset.
module tb_mem_access_unit;

    localparam int ADDR_W  = 17;
    localparam int TIMEOUT = 4;

    logic              clk;
    logic              reset;
    logic              start;
    logic              op_load;
    logic              op_store;
    logic [1:0]        size;
    logic              sign_ext;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;
    logic [31:0]       rdata;
    logic              done;
    logic              busy;
    logic              err;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_unit #(
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op_load  (op_load),
        .op_store (op_store),
        .size     (size),
        .sign_ext (sign_ext),
        .addr     (addr),
        .wdata    (wdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_be   (mem_be),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .rdata    (rdata),
        .done     (done),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a descriptor with a one-cycle start strobe.
    task automatic issue(input logic ld, input logic st, input logic [1:0] sz,
                         input logic sx, input logic [31:0] a, input logic [31:0] wd);
        op_load  = ld;
        op_store = st;
        size     = sz;
        sign_ext = sx;
        addr     = a;
        wdata    = wd;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Hold ready low for 'waits' REQ cycles, then answer with rd.
    task automatic run_req(input int waits, input logic [31:0] rd, input logic [3:0] exp_be);
        for (int i = 0; i < waits; i++) begin
            check("req_wait", 32'(mem_req), 32'd1);
            check("be_stable", 32'(mem_be), 32'(exp_be));
            tick();
        end
        check("req_last", 32'(mem_req), 32'd1);
        mem_ready = 1'b1;
        mem_rdata = rd;
        tick();
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        op_load   = 1'b0;
        op_store  = 1'b0;
        size      = 2'b00;
        sign_ext  = 1'b0;
        addr      = 32'h0;
        wdata     = 32'h0;
        mem_rdata = 32'h0;
        mem_ready = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_req",   32'(mem_req),   32'd0);
        check("rst_we",    32'(mem_we),    32'd0);
        check("rst_addr",  32'(mem_addr),  32'd0);
        check("rst_be",    32'(mem_be),    32'd0);
        check("rst_wdata", mem_wdata,      32'd0);
        check("rst_rdata", rdata,          32'd0);
        check("rst_done",  32'(done),      32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_err",   32'(err),       32'd0);
        reset = 1'b0;
        tick();

        // Word load at 0x100, ready on first REQ cycle
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
        check("wl_addr", 32'(mem_addr), 32'h40);
        check("wl_be",   32'(mem_be),   32'hF);
        check("wl_we",   32'(mem_we),   32'd0);
        check("wl_busy", 32'(busy),     32'd1);
        check("wl_done_early", 32'(done), 32'd0);
        run_req(0, 32'hDEAD_BEEF, 4'hF);
        check("wl_done",  32'(done),    32'd1);
        check("wl_rdata", rdata,        32'hDEAD_BEEF);
        check("wl_err",   32'(err),     32'd0);
        check("wl_req_off", 32'(mem_req), 32'd0);
        tick();
        check("wl_done_pulse", 32'(done), 32'd0);
        check("wl_idle", 32'(busy), 32'd0);

        // Signed byte load at 0x103
        issue(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0);
        check("bl_addr", 32'(mem_addr), 32'h40);
        check("bl_be",   32'(mem_be),   32'h8);
        run_req(0, 32'h80AA_BBCC, 4'h8);
        check("bl_sx_rdata", rdata, 32'hFFFF_FF80);
        tick();

        // Same access, zero-extended
        issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0);
        run_req(1, 32'h80AA_BBCC, 4'h8);
        check("bl_zx_rdata", rdata, 32'h0000_0080);
        tick();

        // Signed half load from upper lane at 0x6
        issue(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0006, 32'h0);
        check("hl_addr", 32'(mem_addr), 32'h1);
        check("hl_be",   32'(mem_be),   32'hC);
        run_req(0, 32'h8001_0000, 4'hC);
        check("hl_rdata", rdata, 32'hFFFF_8001);
        tick();

        // Half store at 0x202 with 3 wait cycles
        issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h1234_ABCD);
        check("hs_addr",  32'(mem_addr), 32'h80);
        check("hs_we",    32'(mem_we),   32'd1);
        check("hs_wdata", mem_wdata,     32'hABCD_ABCD);
        run_req(3, 32'h5555_5555, 4'hC);
        check("hs_done",  32'(done), 32'd1);
        check("hs_err",   32'(err),  32'd0);
        check("hs_rdata_keep", rdata, 32'hFFFF_8001);
        tick();

        // Misaligned word load at 0x2
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0002, 32'h0);
        check("mw_req",  32'(mem_req), 32'd0);
        check("mw_done", 32'(done),    32'd1);
        check("mw_err",  32'(err),     32'd1);
        tick();
        check("mw_done_pulse", 32'(done), 32'd0);
        check("mw_err_hold",   32'(err),  32'd1);
        check("mw_rdata_keep", rdata,     32'hFFFF_8001);

        // Misaligned half load at 0x5
        issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0005, 32'h0);
        check("mh_req",  32'(mem_req), 32'd0);
        check("mh_done", 32'(done),    32'd1);
        check("mh_err",  32'(err),     32'd1);
        tick();

        // Illegal size
        issue(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0);
        check("il_req", 32'(mem_req), 32'd0);
        check("il_err", 32'(err),     32'd1);
        tick();

        // Load and store both set
        issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h0);
        check("ls_req", 32'(mem_req), 32'd0);
        check("ls_err", 32'(err),     32'd1);
        tick();

        // No-op completes without a request and without error
        issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0);
        check("nop_req",  32'(mem_req), 32'd0);
        check("nop_done", 32'(done),    32'd1);
        check("nop_err",  32'(err),     32'd0);
        tick();
        check("nop_rdata_keep", rdata, 32'hFFFF_8001);

        // Timeout: ready held low, request lasts exactly TIMEOUT cycles
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0);
        for (int i = 0; i < TIMEOUT; i++) begin
            check("to_req", 32'(mem_req), 32'd1);
            tick();
        end
        check("to_req_off", 32'(mem_req), 32'd0);
        check("to_done",    32'(done),    32'd1);
        check("to_err",     32'(err),     32'd1);
        check("to_rdata_keep", rdata,     32'hFFFF_8001);
        tick();

        // Start pulsed during REQ is ignored
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0);
        check("ig_addr", 32'(mem_addr), 32'h8);
        check("ig_err_clear", 32'(err), 32'd0);
        addr  = 32'h0000_0044;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ig_addr_stable", 32'(mem_addr), 32'h8);
        run_req(0, 32'h1122_3344, 4'hF);
        check("ig_done",  32'(done), 32'd1);
        check("ig_rdata", rdata,     32'h1122_3344);
        tick();
        tick();
        check("ig_no_second", 32'(busy), 32'd0);
        check("ig_no_req",    32'(mem_req), 32'd0);

        // Reset mid-REQ
        issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0030, 32'hCAFE_F00D);
        check("rm_req", 32'(mem_req), 32'd1);
        reset = 1'b1;
        tick();
        check("rm_req_off", 32'(mem_req), 32'd0);
        check("rm_busy",    32'(busy),    32'd0);
        check("rm_done",    32'(done),    32'd0);
        check("rm_rdata",   rdata,        32'd0);
        reset = 1'b0;
        tick();
        check("rm_no_done", 32'(done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
